main_controller: RTL and testbench

Multicycle main control FSM for the MIPS-style datapath. It consumes the 3-bit instruction opcode from the instruction register and sequences fetch, decode, execute, memory and write-back. Each cycle it drives the datapath enables and the 2-bit `alu_op` class that the ALU control decoder expands into an ALU function. It also inserts memory wait states on `mem_ready` and pulses `instr_done` at instruction retirement.

---
 rtl/mips_ctrl_pkg.sv | 53 +++++
 rtl/main_ctrl_decode.sv | 74 +++++++
 rtl/main_controller.sv | 112 +++++++++++
 tb/tb_main_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-style main controller and the
// downstream ALU control decoder: state encoding, opcodes and ALU classes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_RTEXEC = 4'd6,
        ST_RTWB   = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9
    } state_e;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_JUMP  = 3'b010;
    localparam logic [2:0] OP_BEQZ  = 3'b011;
    // Value of opcode[2] that marks an ALU instruction; [1:0] decoded downstream.
    localparam logic       OP_ALU   = 1'b1;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/main_ctrl_decode.sv
// Per-state datapath control decode; strobes that complete a memory access
// are qualified by mem_ready so they fire only on the completing cycle.
module main_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // Moore decode of the current state, with mem_ready qualification in FETCH and MEMWR
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            ST_RTEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            ST_RTWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_src        = PCSRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
                ctrl.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/main_controller.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/write-back,
// inserts memory wait states and pulses instr_done at retirement.
module main_controller
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               instr_done
);

    state_e state_q, state_d;
    logic   active_q, active_d;
    ctrl_t  ctrl_s;
    ctrl_t  ctrl_out_s;

    // Next-state logic; the FSM holds in FETCH until the first edge after reset release
    always_comb begin
        state_d  = state_q;
        active_d = 1'b1;
        if (!active_q) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_ready) state_d = ST_DECODE;
                    else           state_d = ST_FETCH;
                end
                ST_DECODE: begin
                    if (opcode[2] == OP_ALU) begin
                        state_d = ST_RTEXEC;
                    end else begin
                        case (opcode)
                            OP_LOAD, OP_STORE: state_d = ST_MEMADR;
                            OP_JUMP:           state_d = ST_JUMP;
                            OP_BEQZ:           state_d = ST_BRANCH;
                            default:           state_d = ST_FETCH;
                        endcase
                    end
                end
                ST_MEMADR: begin
                    if (opcode == OP_STORE) state_d = ST_MEMWR;
                    else                    state_d = ST_MEMRD;
                end
                ST_MEMRD: begin
                    if (mem_ready) state_d = ST_MEMWB;
                    else           state_d = ST_MEMRD;
                end
                ST_MEMWR: begin
                    if (mem_ready) state_d = ST_FETCH;
                    else           state_d = ST_MEMWR;
                end
                ST_RTEXEC: state_d = ST_RTWB;
                ST_MEMWB, ST_RTWB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
                default:   state_d = ST_FETCH;
            endcase
        end
    end

    // State register; active_q keeps every output low until fetching begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
        end
    end

    main_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_s)
    );

    // Force the control vector idle while reset is held or just released
    always_comb begin
        if (active_q) ctrl_out_s = ctrl_s;
        else          ctrl_out_s = '0;
    end

    assign pc_write      = ctrl_out_s.pc_write;
    assign pc_write_cond = ctrl_out_s.pc_write_cond;
    assign i_or_d        = ctrl_out_s.i_or_d;
    assign mem_read      = ctrl_out_s.mem_read;
    assign mem_write     = ctrl_out_s.mem_write;
    assign ir_write      = ctrl_out_s.ir_write;
    assign mem_to_reg    = ctrl_out_s.mem_to_reg;
    assign reg_write     = ctrl_out_s.reg_write;
    assign alu_src_a     = ctrl_out_s.alu_src_a;
    assign alu_src_b     = ctrl_out_s.alu_src_b;
    assign pc_src        = ctrl_out_s.pc_src;
    assign alu_op        = ALUOP_W'(ctrl_out_s.alu_op);
    assign instr_done    = ctrl_out_s.instr_done;

endmodule

// File: tb/tb_main_controller.sv
// Randomized scoreboard bench for main_controller: a driver expands each
// instruction into its expected per-cycle control vectors, a monitor compares.
module tb_main_controller;

    logic       clk;
    logic       rst_n;
    logic [2:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, alu_src_a, instr_done;
    logic [1:0] alu_src_b, pc_src, alu_op;

    int checks = 0;
    int errors = 0;
    int exp_done_cnt = 0;
    int dut_done_cnt = 0;
    logic [15:0] exp_q[$];

    main_controller #(.ALUOP_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_src        (pc_src),
        .alu_op        (alu_op),
        .instr_done    (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] vec(input logic pcw, input logic pcwc, input logic iord,
                                        input logic mr, input logic mw, input logic irw,
                                        input logic m2r, input logic rw, input logic asa,
                                        input logic [1:0] asb, input logic [1:0] ps,
                                        input logic [1:0] aop, input logic done);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rw, asa, asb, ps, aop, done};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src, alu_op, instr_done};
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Expected control vectors per instruction phase
    localparam logic [15:0] V_IDLE      = 16'h0000;
    logic [15:0] v_fetch_wait, v_fetch_go, v_decode, v_memadr, v_memrd, v_memwb;
    logic [15:0] v_memwr_wait, v_memwr_go, v_rtexec, v_rtwb, v_branch, v_jump;

    initial begin
        //                  pcw   pcwc  iord  mr    mw    irw   m2r   rw    asa   asb    ps     aop    done
        v_fetch_wait = vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
        v_fetch_go   = vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
        v_decode     = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0);
        v_memadr     = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0);
        v_memrd      = vec(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        v_memwb      = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
        v_memwr_wait = vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        v_memwr_go   = vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
        v_rtexec     = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b10, 1'b0);
        v_rtwb       = vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
        v_branch     = vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b1);
        v_jump       = vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b1);
    end

    function automatic logic [2:0] rnd_op();
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle of stimulus with its expected DUT response
    task automatic step(input logic mr, input logic [2:0] op, input logic [15:0] exp);
        mem_ready = mr;
        opcode    = op;
        exp_q.push_back(exp);
        if (exp[0]) exp_done_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Expand one instruction into its cycle sequence; opcode is noise outside DECODE/MEMADR
    task automatic issue(input logic [2:0] op, input int wf, input int wm);
        for (int i = 0; i < wf; i++) step(1'b0, rnd_op(), v_fetch_wait);
        step(1'b1, rnd_op(), v_fetch_go);
        step(rnd_bit(), op, v_decode);
        if (op[2]) begin
            step(rnd_bit(), rnd_op(), v_rtexec);
            step(rnd_bit(), rnd_op(), v_rtwb);
        end else if (op == 3'b000) begin
            step(rnd_bit(), op, v_memadr);
            for (int i = 0; i < wm; i++) step(1'b0, rnd_op(), v_memrd);
            step(1'b1, rnd_op(), v_memrd);
            step(rnd_bit(), rnd_op(), v_memwb);
        end else if (op == 3'b001) begin
            step(rnd_bit(), op, v_memadr);
            for (int i = 0; i < wm; i++) step(1'b0, rnd_op(), v_memwr_wait);
            step(1'b1, rnd_op(), v_memwr_go);
        end else if (op == 3'b010) begin
            step(rnd_bit(), rnd_op(), v_jump);
        end else begin
            step(rnd_bit(), rnd_op(), v_branch);
        end
    endtask

    task automatic hold_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("reset_idle", dut_vec(), V_IDLE);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 3'b110, V_IDLE);
    endtask

    // Monitor: compare every cycle that has an expected vector queued
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (instr_done) dut_done_cnt++;
            chk("ctrl", dut_vec(), e);
        end
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = 3'b110;
        mem_ready = 1'b1;
        hold_reset(3);

        issue(3'b101, 0, 0);
        issue(3'b000, 0, 2);
        issue(3'b001, 0, 0);
        issue(3'b011, 0, 0);
        issue(3'b010, 0, 0);

        // STORE aborted by asynchronous reset while waiting in MEMWR
        step(1'b1, rnd_op(), v_fetch_go);
        step(1'b1, 3'b001, v_decode);
        step(1'b1, 3'b001, v_memadr);
        mem_ready = 1'b0;
        opcode    = rnd_op();
        #1;
        chk("memwr_wait", dut_vec(), v_memwr_wait);
        rst_n = 1'b0;
        #1;
        chk("async_clear", dut_vec(), V_IDLE);
        mem_ready = 1'b1;
        hold_reset(2);

        issue(3'b000, 1, 0);
        for (int n = 0; n < 300; n++) begin
            issue(rnd_op(), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end
        checks++;
        if (dut_done_cnt != exp_done_cnt) begin
            errors++;
            $display("FAIL done_count: got %0d expected %0d", dut_done_cnt, exp_done_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
